// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial N-bit subtractor computing Diff = A - B - Bin (unsigned, modulo
// 2^N) together with the borrow-out Bout. It processes one bit per clock, LSB
// first, and keeps a single borrow flip-flop between bits. This is the low-area
// subtract path. A start/busy/done handshake controls it.
//
// Ports
//   clk    in   1  single clock, rising-edge active
//   rst    in   1  asynchronous, active-high reset
//   start  in   1  request; sampled on each rising edge while busy=0
//   A      in   N  minuend, captured on the accepting start edge
//   B      in   N  subtrahend, captured on the accepting start edge
//   Bin    in   1  borrow-in, captured on the accepting start edge
//   busy   out  1  high while the bit-serial operation runs (SHIFT state)
//   done   out  1  one-cycle pulse; Diff and Bout are valid from this cycle
//   Diff   out  N  result; holds its value until the next completion
//   Bout   out  1  borrow-out; 1 iff A < B + Bin (unsigned)
//
// Timing
//   The start edge k loads the operands. Edges k+1 .. k+N process bits
//   0 .. N-1. done is high in the cycle after edge k+N. If start is high
//   during the DONE cycle, the next operation is accepted at once. This gives
//   one result every N+1 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
  output logic         Bout
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_a_sr;
  logic [N-1:0]     r_b_sr;
  // Holds only the upper N-1 result bits. The bit that a full N-bit shift
  // register would push out of position 0 is never observed, so it is not kept.
  logic [N-2:0]     r_d_sr;
  logic             r_brw;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_diff;
  logic             r_bout;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_brw_nxt;
  logic             w_last;
  logic [N-1:0]     w_d_word;

  // One-bit full subtractor on the current LSBs.
  assign w_a_bit   = r_a_sr[0];
  assign w_b_bit   = r_b_sr[0];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_brw;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow is pending.
  assign w_brw_nxt = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_brw);
  assign w_last    = (r_cnt == LAST_BIT);

  // Result word after this bit has been shifted in. It is complete on the last bit.
  assign w_d_word  = {w_d, r_d_sr};

  // NOTE: all state uses non-blocking assignments so that every register
  // samples pre-edge values; blocking here would chain the shift stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well as the control, so an
      // aborted operation leaves no stale partial result behind.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_d_sr  <= '0;
      r_brw   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          r_brw  <= w_brw_nxt;
          r_d_sr <= w_d_word[N-1:1];
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_d_word;
            r_bout  <= w_brw_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        // IDLE and DONE both accept a new request. DONE otherwise falls back
        // to IDLE, which keeps the done pulse exactly one cycle wide.
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_brw   <= Bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule
